// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Purpose  : Moore control sequencer for an add/sub, Booth radix-2 multiply and
//            non-restoring divide datapath. Optional divide-by-zero trap is
//            enabled by defining ALU_CTRL_DIVZ_CHK_EN.
// Revision : 1.0  initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  sel,
    input  logic        q0,
    input  logic        qm1,
    input  logic        sign,
`ifdef ALU_CTRL_DIVZ_CHK_EN
    input  logic        divz,
    output logic        err,
`endif
    output logic [11:0] c,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_AS,
        S_LD_MUL,
        S_LD_DIV,
        S_INIT,
        S_ADD,
        S_SUB,
        S_MSHR,
        S_MNEXT,
        S_DSHL,
        S_DQBIT,
        S_CORR,
        S_ST_LO,
        S_ST_HI
`ifdef ALU_CTRL_DIVZ_CHK_EN
        , S_ERR
`endif
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d, booth_st;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             done_q, done_d;

    // Booth recoding of the current multiplier pair {Q[0], Q[-1]}
    always_comb begin
        case ({q0, qm1})
            2'b01:   booth_st = S_ADD;
            2'b10:   booth_st = S_SUB;
            default: booth_st = S_MSHR;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        c       = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d = sel;
                    if (!sel[1])     state_d = S_LD_AS;
                    else if (!sel[0]) state_d = S_LD_MUL;
                    else             state_d = S_LD_DIV;
                end
            end
            S_LD_AS: begin
                c[0]    = 1'b1;
                state_d = S_INIT;
            end
            S_LD_MUL: begin
                c[1]    = 1'b1;
                state_d = S_INIT;
            end
            S_LD_DIV: begin
                c[2]    = 1'b1;
                state_d = S_INIT;
            end
            S_INIT: begin
                c[3]  = 1'b1;
                cnt_d = '0;
                case (sel_q)
                    2'b00:   state_d = S_ADD;
                    2'b01:   state_d = S_SUB;
                    2'b10:   state_d = booth_st;
`ifdef ALU_CTRL_DIVZ_CHK_EN
                    default: state_d = divz ? S_ERR : S_DSHL;
`else
                    default: state_d = S_DSHL;
`endif
                endcase
            end
            S_ADD, S_SUB: begin
                c[4] = 1'b1;
                c[5] = (state_q == S_SUB);
                if (!sel_q[1])      state_d = S_ST_LO;
                else if (!sel_q[0]) state_d = S_MSHR;
                else                state_d = S_DQBIT;
            end
            S_MSHR: begin
                c[7]    = 1'b1;
                state_d = S_MNEXT;
            end
            S_MNEXT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_ST_LO;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = booth_st;
                end
            end
            // Non-restoring step: add back when the partial remainder is negative
            S_DSHL: begin
                c[6]    = 1'b1;
                state_d = sign ? S_ADD : S_SUB;
            end
            S_DQBIT: begin
                c[8] = 1'b1;
                if (cnt_q != CNT_LAST) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_DSHL;
                end else begin
                    state_d = sign ? S_CORR : S_ST_LO;
                end
            end
            S_CORR: begin
                c[4]    = 1'b1;
                c[9]    = 1'b1;
                state_d = S_ST_LO;
            end
            S_ST_LO: begin
                c[10]   = 1'b1;
                done_d  = !sel_q[1];
                state_d = sel_q[1] ? S_ST_HI : S_IDLE;
            end
            S_ST_HI: begin
                c[11]   = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
`ifdef ALU_CTRL_DIVZ_CHK_EN
            S_ERR: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

`ifdef ALU_CTRL_DIVZ_CHK_EN
    logic err_q;

    // Sticky until the next accepted start so software can read it after done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_d == S_ERR) begin
            err_q <= 1'b1;
        end else if (state_q == S_IDLE && start) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`endif

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width; sets iteration count for multiply/divide (legal range 2..64).
REQ-002 Parameter: CNT_W, default $clog2(WIDTH), iteration-counter width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin an operation; sampled only in IDLE.
REQ-006 sel  input  2  operation: 00 add, 01 sub, 10 Booth radix-2 multiply, 11 non-restoring divide.
REQ-007 q0, qm1  input  1 each  datapath Q[0] and Q[-1] (Booth pair).
REQ-008 sign  input  1  datapath accumulator sign bit.
REQ-009 c  output  12  control word: c[0] load add/sub operands, c[1] load mul operands, c[2] load div operands, c[3] init (clear A, Q[-1]), c[4] adder enable, c[5] subtract select, c[6] left shift A:Q, c[7] arithmetic right shift A:Q:Q[-1], c[8] write Q[0]=~sign, c[9] remainder correction (A+=M), c[10] store result low, c[11] store result high.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle completion pulse.

Function
REQ-012 States: IDLE, LD_AS, LD_MUL, LD_DIV, INIT, ADD, SUB, MSHR, MNEXT, DSHL, DQBIT, CORR, ST_LO, ST_HI; Moore outputs decoded from state only.
REQ-013 Per-state c bits: LD_AS c0; LD_MUL c1; LD_DIV c2; INIT c3; ADD c4; SUB c4,c5; MSHR c7; DSHL c6; DQBIT c8; CORR c4,c9; ST_LO c10; ST_HI c11; IDLE/MNEXT none.
REQ-014 sel is registered into sel_r on the IDLE->LD_* edge; all later branching uses sel_r; sel changes mid-operation are ignored.
REQ-015 IDLE: start=1 -> LD_AS (sel=0x), LD_MUL (10), LD_DIV (11); start=0 stays; start while busy is ignored.
REQ-016 LD_* -> INIT; INIT clears iteration counter cnt to 0.
REQ-017 INIT: sel_r 00 -> ADD, 01 -> SUB, 10 -> Booth branch, 11 -> DSHL.
REQ-018 Booth branch on {q0,qm1}: 01 -> ADD, 10 -> SUB, 00/11 -> MSHR; ADD/SUB with sel_r=10 -> MSHR; MSHR -> MNEXT.
REQ-019 MNEXT: cnt==WIDTH-1 -> ST_LO; else cnt<=cnt+1 and take Booth branch on post-shift {q0,qm1}.
REQ-020 Divide: DSHL -> ADD if sign=1 else SUB; ADD/SUB with sel_r=11 -> DQBIT.
REQ-021 DQBIT: cnt!=WIDTH-1 -> cnt<=cnt+1, DSHL; cnt==WIDTH-1 and sign=1 -> CORR; sign=0 -> ST_LO; CORR -> ST_LO.
REQ-022 ADD/SUB with sel_r=0x -> ST_LO; ST_LO -> IDLE for sel_r=0x, else ST_HI; ST_HI -> IDLE.
REQ-023 done is registered, high exactly the first IDLE cycle after ST_LO (add/sub) or ST_HI (mul/div).
REQ-024 Latency from start-sampling edge to done: add/sub 5 cycles; multiply 2*WIDTH+5 plus one per ADD/SUB visit; divide 3*WIDTH+5, +1 if CORR.
REQ-025 start held high continuously re-launches one cycle after done; exactly one operation per IDLE visit.

Reset
REQ-026 rst=1 forces IDLE, cnt=0, sel_r=00, c=0, busy=0, done=0 asynchronously, including mid-operation; no done pulse is produced for the aborted operation.

Configuration
REQ-027 Macro ALU_CTRL_DIVZ_CHK_EN: when defined, adds input divz (1, divisor is zero) and output err (1); INIT with sel_r=11 and divz=1 -> ERR state (c=0) -> IDLE with done pulse; err set on entry to ERR, held until next start accepted.
REQ-028 Without ALU_CTRL_DIVZ_CHK_EN: no divz/err ports, no ERR state; divide by zero runs the normal divide sequence.

Verification
REQ-029 WIDTH=8, start with sel=00 -> c0,c3,c4,c10 one cycle each in order, done 5 cycles after start edge, busy high 4 cycles.
REQ-030 sel=10, {q0,qm1} held 00 -> eight MSHR/MNEXT pairs, no c4, ST_LO then ST_HI, done at cycle 21.
REQ-031 sel=11, sign held 0 -> eight DSHL/SUB/DQBIT triples, no CORR, done at cycle 29; sign held 1 -> ADD each iteration, CORR once, done at cycle 30.
REQ-032 sel changed from 10 to 00 two cycles after start -> multiply sequence completes unchanged.
REQ-033 rst pulsed during divide iteration 3 -> c=0, busy=0 immediately, no done; next start runs a full operation.
REQ-034 With ALU_CTRL_DIVZ_CHK_EN, sel=11, divz=1 -> LD_DIV, INIT, ERR, done at cycle 4, err=1 until next start.
